// File: rtl/pid_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pid_disp_pkg
// Description : Segment codes, mode encodings and overrange limits shared by
//               the PID parameter display and its BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package pid_disp_pkg;

    localparam logic [1:0] MODE_TEMP = 2'd0;
    localparam logic [1:0] MODE_P    = 2'd1;
    localparam logic [1:0] MODE_I    = 2'd2;
    localparam logic [1:0] MODE_D    = 2'd3;

    localparam logic [7:0] c_seg_blank = 8'hFF;
    localparam logic [7:0] c_seg_dash  = 8'hBF;
    localparam logic [7:0] c_seg_p     = 8'h8C;
    localparam logic [7:0] c_seg_i     = 8'hFB;
    localparam logic [7:0] c_seg_d     = 8'hA1;
    localparam logic [7:0] c_seg_e     = 8'h86;

    localparam logic [9:0] c_temp_max  = 10'd999;
    localparam logic [9:0] c_param_max = 10'd99;

    // Active-low {dp,g,f,e,d,c,b,a} pattern for one decimal digit
    function automatic logic [7:0] seg_digit(input logic [3:0] n);
        logic [7:0] w_code;
        case (n)
            4'd0:    w_code = 8'hC0;
            4'd1:    w_code = 8'hF9;
            4'd2:    w_code = 8'hA4;
            4'd3:    w_code = 8'hB0;
            4'd4:    w_code = 8'h99;
            4'd5:    w_code = 8'h92;
            4'd6:    w_code = 8'h82;
            4'd7:    w_code = 8'hF8;
            4'd8:    w_code = 8'h80;
            4'd9:    w_code = 8'h90;
            default: w_code = c_seg_blank;
        endcase
        return w_code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble converter, 10-bit binary to 3 BCD
//               digits; done pulses on the 11th cycle after start.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [21:0] r_sh;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [21:0] w_adj;

    // Add-3 correction on each BCD nibble ahead of the shift
    always_comb begin
        w_adj = r_sh;
        for (int k = 0; k < 3; k++) begin
            if (w_adj[10+4*k +: 4] >= 4'd5)
                w_adj[10+4*k +: 4] = w_adj[10+4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_sh  <= {w_adj[20:0], 1'b0};
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (start) begin
                r_sh   <= {12'd0, bin};
                r_cnt  <= 4'd10;
                r_busy <= 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_sh[21:10];

endmodule
`default_nettype wire

// File: rtl/pid_param_display.sv
`default_nettype none
// ============================================================================
// Module      : pid_param_display
// Description : 4-digit multiplexed 7-segment display of the PID parameter
//               being adjusted, falling back to temperature after a hold time.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_param_display
    import pid_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] p_pa,
    input  logic [9:0] i_pa,
    input  logic [9:0] d_pa,
    input  logic [1:0] pid_show,
    input  logic [9:0] temp_val,
    output logic [7:0] seg,
    output logic [3:0] dig_sel
);

    localparam int c_scan_w = $clog2(SCAN_DIV);
    localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES - 1);

    logic [1:0]          r_mode;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_scan_w-1:0] r_scan_cnt;
    logic [1:0]          r_idx;
    logic                r_start;
    logic [9:0]          r_snap_val;
    logic [1:0]          r_snap_mode;
    logic [3:0][7:0]     r_dig;
    logic [7:0]          r_seg;
    logic [3:0]          r_dig_sel;

    logic [9:0]          w_src_val;
    logic                w_frame_start;
    logic                w_busy;
    logic                w_done;
    logic [11:0]         w_bcd;
    logic [3:0][7:0]     w_fmt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= MODE_TEMP;
            r_hold_cnt <= '0;
        end else if (pid_show != MODE_TEMP) begin
            r_mode     <= pid_show;
            r_hold_cnt <= c_hold_load;
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
        end else begin
            r_mode     <= MODE_TEMP;
        end
    end

    always_comb begin
        case (r_mode)
            MODE_P:  w_src_val = p_pa;
            MODE_I:  w_src_val = i_pa;
            MODE_D:  w_src_val = d_pa;
            default: w_src_val = temp_val;
        endcase
    end

    // Digits are scanned left to right: index 3,2,1,0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (r_scan_cnt == c_scan_last) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx - 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign w_frame_start = (r_idx == 2'd3) && (r_scan_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start     <= 1'b0;
            r_snap_val  <= '0;
            r_snap_mode <= MODE_TEMP;
        end else begin
            r_start <= 1'b0;
            if (w_frame_start && !w_busy && !r_start) begin
                r_snap_val  <= w_src_val;
                r_snap_mode <= r_mode;
                r_start     <= 1'b1;
            end
        end
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (r_start),
        .bin   (r_snap_val),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_comb begin
        w_fmt = {4{c_seg_blank}};
        if (r_snap_mode == MODE_TEMP) begin
            if (r_snap_val > c_temp_max) begin
                w_fmt[2:0] = {3{c_seg_e}};
            end else begin
                w_fmt[2] = (w_bcd[11:8] == 4'd0) ? c_seg_blank : seg_digit(w_bcd[11:8]);
                w_fmt[1] = (w_bcd[11:4] == 8'd0) ? c_seg_blank : seg_digit(w_bcd[7:4]);
                w_fmt[0] = seg_digit(w_bcd[3:0]);
            end
        end else begin
            case (r_snap_mode)
                MODE_P:  w_fmt[3] = c_seg_p;
                MODE_I:  w_fmt[3] = c_seg_i;
                default: w_fmt[3] = c_seg_d;
            endcase
            w_fmt[2] = c_seg_dash;
            if (r_snap_val > c_param_max) begin
                w_fmt[1:0] = {2{c_seg_e}};
            end else begin
                w_fmt[1] = seg_digit(w_bcd[7:4]);
                w_fmt[0] = seg_digit(w_bcd[3:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig     <= {4{c_seg_blank}};
            r_seg     <= c_seg_blank;
            r_dig_sel <= 4'b1111;
        end else begin
            if (w_done)
                r_dig <= w_fmt;
            r_seg     <= r_dig[r_idx];
            r_dig_sel <= ~(4'b0001 << r_idx);
        end
    end

    assign seg     = r_seg;
    assign dig_sel = r_dig_sel;

endmodule
`default_nettype wire

// File: tb/tb_pid_param_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_pid_param_display
// Description : Randomized self-checking bench comparing displayed frames
//               against an arithmetic model of the display format.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_param_display;

    localparam int SCAN = 4;
    localparam int HOLD = 100;
    localparam logic [7:0] DIG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    localparam logic [7:0] LTR_TBL [4]  = '{8'hFF, 8'h8C, 8'hFB, 8'hA1};

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] p_pa, i_pa, d_pa, temp_val;
    logic [1:0] pid_show;
    logic [7:0] seg;
    logic [3:0] dig_sel;

    int n_vec = 0;
    int n_err = 0;

    pid_param_display #(.SCAN_DIV(SCAN), .HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .p_pa     (p_pa),
        .i_pa     (i_pa),
        .d_pa     (d_pa),
        .pid_show (pid_show),
        .temp_val (temp_val),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Expected {digit3,digit2,digit1,digit0} for a mode/value pair
    function automatic logic [31:0] exp_frame(input int mode, input int val);
        logic [7:0] d2, d1;
        if (mode == 0) begin
            if (val > 999) return {8'hFF, 8'h86, 8'h86, 8'h86};
            d2 = (val < 100) ? 8'hFF : DIG_TBL[val / 100];
            d1 = (val < 10)  ? 8'hFF : DIG_TBL[(val / 10) % 10];
            return {8'hFF, d2, d1, DIG_TBL[val % 10]};
        end
        if (val > 99) return {LTR_TBL[mode], 8'hBF, 8'h86, 8'h86};
        return {LTR_TBL[mode], 8'hBF, DIG_TBL[val / 10], DIG_TBL[val % 10]};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the leftmost slot, then compare all four slots of one frame
    task automatic capture(input string tag, input logic [31:0] exp);
        int waited = 0;
        while (dig_sel !== 4'b0111 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (dig_sel !== 4'b0111) begin
            chk({tag, "_frame_timeout"}, {28'd0, dig_sel}, 32'h7);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_dig_sel"}, {28'd0, dig_sel}, {28'd0, ~(4'b1000 >> k)});
            chk({tag, "_seg"}, {24'd0, seg}, {24'd0, exp[31-8*k -: 8]});
            cycles(SCAN);
        end
    endtask

    initial begin
        int m, v, bad, dones;
        logic [9:0] vals[4];

        rst = 1'b1; p_pa = '0; i_pa = '0; d_pa = '0; pid_show = 2'd0; temp_val = 10'd253;
        cycles(5);
        chk("reset_seg", {24'd0, seg}, 32'hFF);
        chk("reset_dig_sel", {28'd0, dig_sel}, 32'hF);
        rst = 1'b0;
        cycles(40);
        capture("temp_253", exp_frame(0, 253));

        pid_show = 2'd1; p_pa = 10'd70;
        cycles(25);
        pid_show = 2'd0;
        cycles(70);
        capture("p_hold", exp_frame(1, 70));
        cycles(60);
        capture("revert_temp", exp_frame(0, 253));

        pid_show = 2'd2; i_pa = 10'd5;
        cycles(40);
        capture("i_5", exp_frame(2, 5));
        pid_show = 2'd3; d_pa = 10'd120;
        cycles(40);
        capture("d_120", exp_frame(3, 120));

        pid_show = 2'd0;
        temp_val = 10'd1000; cycles(HOLD + 50);
        capture("temp_1000", exp_frame(0, 1000));
        temp_val = 10'd7; cycles(40);
        capture("temp_7", exp_frame(0, 7));
        temp_val = 10'd40; cycles(40);
        capture("temp_40", exp_frame(0, 40));

        // Reset while a conversion of a new value is in flight
        temp_val = 10'd888;
        capture("pre_abort", exp_frame(0, 40));
        while (dig_sel !== 4'b0111) @(negedge clk);
        cycles(3);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_seg", {24'd0, seg}, 32'hFF);
        chk("abort_dig_sel", {28'd0, dig_sel}, 32'hF);
        bad = 0; dones = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (seg !== 8'hFF) bad++;
            if (dut.u_conv.done) dones++;
        end
        chk("abort_no_stale", bad, 0);
        chk("abort_no_done", dones, 0);
        cycles(40);
        capture("after_abort", exp_frame(0, 888));

        for (int it = 0; it < 12; it++) begin
            m = $urandom_range(0, 3);
            for (int j = 0; j < 4; j++) begin
                v = (j == 0) ? 999 : 99;
                if ($urandom_range(0, 3) == 0) vals[j] = 10'($urandom_range(v + 1, 1023));
                else                           vals[j] = 10'($urandom_range(0, v));
            end
            temp_val = vals[0]; p_pa = vals[1]; i_pa = vals[2]; d_pa = vals[3];
            pid_show = 2'(m);
            cycles((m == 0) ? HOLD + 50 : 45);
            capture($sformatf("rand%0d_m%0d", it, m), exp_frame(m, int'(vals[m])));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
